uart_rx_frame: RTL and testbench

- Parametrised UART receiver, successor to the fixed 8N1 receiver in the serial link path.
- Runs entirely on the system clock, using a baud-tick enable instead of a derived clock.
- Supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits.
- Adds 3-sample majority voting, false-start rejection, framing/parity/overrun error flags and a valid/ready output handshake toward the consumer.

---
 rtl/uart_rx_frame.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver, 5-9 data bits, optional parity,
// 1-2 stop bits, 3-sample majority vote, valid/ready output with error flags.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   rx               asynchronous serial line (idle high)
//   rx_ready         consumer accepts the held word
//   rx_data          received word (LSB first on the line)
//   rx_valid         rx_data and error flags are valid
//   parity_err       parity mismatch on the held word
//   frame_err        a stop bit was voted low on the held word
//   overrun_err      the held word replaced an unconsumed word
//   busy             receiver is inside a frame

module uart_rx_frame #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] S_LO     = SW'(M - 1);
    localparam logic [SW-1:0] S_MID    = SW'(M);
    localparam logic [SW-1:0] S_HI     = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY == 1);
    localparam logic          TWO_STOP = (STOP_BITS == 2);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_frame: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_frame: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_rx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_m_q, rx_s_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 prev_q, prev_d;
    logic [SW-1:0]        s_q, s_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [1:0]           v_q, v_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_pend_q, par_pend_d;
    logic                 frm_pend_q, frm_pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 oe_q, oe_d;

    logic tick;
    logic maj;
    logic at_hi;
    logic s_end;
    logic last_stop;
    logic done;

    assign tick      = (cnt_q == DIV_LAST);
    // third sample is the live synchronised value at s = M+1
    assign maj       = (v_q[0] & v_q[1]) | (v_q[0] & rx_s_q) | (v_q[1] & rx_s_q);
    assign at_hi     = (s_q == S_HI);
    assign s_end     = (s_q == S_LAST);
    assign last_stop = TWO_STOP ? stop_q : 1'b1;
    assign done      = tick && (state_q == STOP) && at_hi && last_stop;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                IDLE:  if (prev_q && !rx_s_q) state_d = START;
                START: begin
                    if (at_hi && maj) state_d = IDLE;
                    else if (s_end)   state_d = DATA;
                end
                DATA:  if (s_end && bit_q == B_LAST) begin
                    state_d = (PARITY != 0) ? PAR : STOP;
                end
                PAR:   if (s_end) state_d = STOP;
                STOP:  if (at_hi && last_stop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // datapath and output next-state logic
    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        prev_d     = prev_q;
        s_d        = s_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        v_d        = v_q;
        shift_d    = shift_q;
        par_pend_d = par_pend_q;
        frm_pend_d = frm_pend_q;
        data_d     = data_q;
        valid_d    = valid_q;
        pe_d       = pe_q;
        fe_d       = fe_q;
        oe_d       = oe_q;

        if (tick) begin
            prev_d = rx_s_q;
            s_d    = s_end ? '0 : s_q + 1'b1;
            if (s_q == S_LO)  v_d[0] = rx_s_q;
            if (s_q == S_MID) v_d[1] = rx_s_q;
            unique case (state_q)
                IDLE: begin
                    s_d        = '0;
                    bit_d      = '0;
                    stop_d     = 1'b0;
                    par_pend_d = 1'b0;
                    frm_pend_d = 1'b0;
                end
                DATA: begin
                    if (at_hi) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (s_end) bit_d = bit_q + 1'b1;
                end
                PAR: begin
                    if (at_hi) par_pend_d = maj ^ (^shift_q) ^ ODD;
                end
                STOP: begin
                    if (at_hi && !maj) frm_pend_d = 1'b1;
                    if (s_end) stop_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (done) begin
            data_d  = shift_q;
            pe_d    = par_pend_q;
            fe_d    = frm_pend_q | ~maj;
            valid_d = 1'b1;
            oe_d    = valid_q & ~rx_ready;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            oe_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= '0;
            prev_q     <= 1'b0;
            s_q        <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            v_q        <= '0;
            shift_q    <= '0;
            par_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            rx_m_q     <= rx;
            rx_s_q     <= rx_m_q;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            s_q        <= s_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            v_q        <= v_d;
            shift_q    <= shift_d;
            par_pend_q <= par_pend_d;
            frm_pend_q <= frm_pend_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            oe_q       <= oe_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = pe_q;
    assign frame_err   = fe_q;
    assign overrun_err = oe_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame with three variants
// (8N1, 8E1, 9N2), each at DIV=4, 16x oversampling, 64 clk per bit.

module tb_uart_rx_frame;

    localparam int BIT = 64;

    logic clk;
    logic rst_n;
    logic [2:0] rx_l;
    logic rdy0;
    logic rdy12;

    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic v0, v1, v2;
    logic pe0, pe1, pe2;
    logic fe0, fe1, fe2;
    logic oe0, oe1, oe2;
    logic b0, b1, b2;

    int total = 0;
    int bad = 0;
    int vcnt [3];
    logic [8:0] ldat [3];
    logic lpe [3];
    logic lfe [3];
    logic loe [3];
    int base;

    uart_rx_frame #(
        .CLK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .rx_ready(rdy0),
        .rx_data(d0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0),
        .overrun_err(oe0), .busy(b0)
    );

    uart_rx_frame #(
        .CLK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .rx_ready(rdy12),
        .rx_data(d1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1),
        .overrun_err(oe1), .busy(b1)
    );

    uart_rx_frame #(
        .CLK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
        .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .rx_ready(rdy12),
        .rx_data(d2), .rx_valid(v2), .parity_err(pe2), .frame_err(fe2),
        .overrun_err(oe2), .busy(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (v0) begin
            vcnt[0] <= vcnt[0] + 1;
            ldat[0] <= {1'b0, d0};
            lpe[0] <= pe0; lfe[0] <= fe0; loe[0] <= oe0;
        end
        if (v1) begin
            vcnt[1] <= vcnt[1] + 1;
            ldat[1] <= {1'b0, d1};
            lpe[1] <= pe1; lfe[1] <= fe1; loe[1] <= oe1;
        end
        if (v2) begin
            vcnt[2] <= vcnt[2] + 1;
            ldat[2] <= d2;
            lpe[2] <= pe2; lfe[2] <= fe2; loe[2] <= oe2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input int n);
        rx_l[k] = v;
        repeat (n) @(negedge clk);
    endtask

    // gl: data bit index that carries a 1-tick low glitch near mid-bit
    task automatic send(input int k, input int nb, input logic [8:0] d,
                        input bit has_par, input logic pbit, input int ns,
                        input logic [1:0] sv, input int gl);
        drive(k, 1'b0, BIT);
        for (int i = 0; i < nb; i++) begin
            if (i == gl) begin
                drive(k, 1'b1, 38);
                drive(k, 1'b0, 4);
                drive(k, 1'b1, BIT - 42);
            end else begin
                drive(k, d[i], BIT);
            end
        end
        if (has_par) drive(k, pbit, BIT);
        for (int i = 0; i < ns; i++) drive(k, sv[i], BIT);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_l  = 3'b011;
        rdy0  = 1'b1;
        rdy12 = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data", {24'd0, d0}, 32'h0);
        chk("reset_valid", v0, 1'b0);
        chk("reset_perr", pe0, 1'b0);
        chk("reset_ferr", fe0, 1'b0);
        chk("reset_oerr", oe0, 1'b0);
        chk("reset_busy", b0, 1'b0);
        rst_n = 1'b1;

        // line already low when reset releases: no frame
        repeat (100) @(negedge clk);
        chk("low_after_reset_busy", b2, 1'b0);
        rx_l[2] = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("low_after_reset_valid", vcnt[2], 0);

        // 0xA5 8N1
        send(0, 8, 9'h0A5, 0, 1'b0, 1, 2'b11, -1);
        chk("a5_count", vcnt[0], 1);
        chk("a5_data", ldat[0], 9'h0A5);
        chk("a5_perr", lpe[0], 1'b0);
        chk("a5_ferr", lfe[0], 1'b0);
        chk("a5_oerr", loe[0], 1'b0);
        chk("a5_busy", b0, 1'b0);
        chk("a5_valid_dropped", v0, 1'b0);

        // even parity: 0x07 has odd weight so parity bit 1 is correct
        send(1, 8, 9'h007, 1, 1'b1, 1, 2'b11, -1);
        chk("par_ok_count", vcnt[1], 1);
        chk("par_ok_data", ldat[1], 9'h007);
        chk("par_ok_perr", lpe[1], 1'b0);
        send(1, 8, 9'h007, 1, 1'b0, 1, 2'b11, -1);
        chk("par_bad_count", vcnt[1], 2);
        chk("par_bad_data", ldat[1], 9'h007);
        chk("par_bad_perr", lpe[1], 1'b1);

        // 0x3C with low stop bit, then line held low (break)
        send(0, 8, 9'h03C, 0, 1'b0, 1, 2'b00, -1);
        repeat (3 * BIT) @(negedge clk);
        chk("brk_count", vcnt[0], 2);
        chk("brk_data", ldat[0], 9'h03C);
        chk("brk_ferr", lfe[0], 1'b1);
        drive(0, 1'b1, BIT);
        chk("brk_no_second", vcnt[0], 2);
        chk("brk_busy", b0, 1'b0);
        send(0, 8, 9'h05A, 0, 1'b0, 1, 2'b11, -1);
        chk("post_brk_count", vcnt[0], 3);
        chk("post_brk_data", ldat[0], 9'h05A);
        chk("post_brk_ferr", lfe[0], 1'b0);

        // false start: low for 4 ticks only
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 4);
        chk("false_start_busy_hi", b0, 1'b1);
        repeat (100) @(negedge clk);
        chk("false_start_busy_lo", b0, 1'b0);
        chk("false_start_novalid", vcnt[0], 3);

        // 0xFF with a single-tick glitch near mid of data bit 3
        send(0, 8, 9'h0FF, 0, 1'b0, 1, 2'b11, 3);
        chk("glitch_count", vcnt[0], 4);
        chk("glitch_data", ldat[0], 9'h0FF);

        // overrun: two frames without consumption
        rdy0 = 1'b0;
        send(0, 8, 9'h011, 0, 1'b0, 1, 2'b11, -1);
        chk("ovr_first_valid", v0, 1'b1);
        chk("ovr_first_data", {24'd0, d0}, 32'h11);
        chk("ovr_first_oerr", oe0, 1'b0);
        send(0, 8, 9'h022, 0, 1'b0, 1, 2'b11, -1);
        chk("ovr_second_valid", v0, 1'b1);
        chk("ovr_second_data", {24'd0, d0}, 32'h22);
        chk("ovr_second_oerr", oe0, 1'b1);
        rdy0 = 1'b1;
        @(negedge clk);
        rdy0 = 1'b0;
        chk("ovr_consumed_valid", v0, 1'b0);
        chk("ovr_consumed_oerr", oe0, 1'b0);
        rdy0 = 1'b1;

        // reset during data bit 3 of 0x099 on the 9N2 variant
        base = vcnt[2];
        drive(2, 1'b0, BIT);
        drive(2, 1'b1, BIT);
        drive(2, 1'b0, BIT);
        drive(2, 1'b0, BIT);
        drive(2, 1'b1, 32);
        chk("mid_busy_before_rst", b2, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_busy", b2, 1'b0);
        chk("mid_rst_valid", v2, 1'b0);
        chk("mid_rst_data", {23'd0, d2}, 32'h0);
        rst_n = 1'b1;
        rx_l[2] = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        chk("mid_rst_no_valid", vcnt[2], base);
        send(2, 9, 9'h1A5, 0, 1'b0, 2, 2'b11, -1);
        chk("n9_count", vcnt[2], base + 1);
        chk("n9_data", ldat[2], 9'h1A5);
        chk("n9_ferr", lfe[2], 1'b0);
        chk("n9_perr", lpe[2], 1'b0);
        chk("n9_oerr", loe[2], 1'b0);

        // second stop bit low only
        send(2, 9, 9'h0F3, 0, 1'b0, 2, 2'b01, -1);
        drive(2, 1'b1, BIT);
        chk("stop2_count", vcnt[2], base + 2);
        chk("stop2_data", ldat[2], 9'h0F3);
        chk("stop2_ferr", lfe[2], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
